fpga_status_led_ctrl: RTL and testbench

FPGA_STATUS_LED_CTRL -- requirements
Module: fpga_status_led_ctrl

---
 rtl/fpga_status_led_ctrl.sv | 92 +++++++++
 tb/tb_fpga_status_led_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fpga_status_led_ctrl.sv
// Status LED controller: free-running blink counter, per-channel LED modes and a latched program-exit code.
// LED and heartbeat outputs are registered with one cycle of latency. There is no backpressure; inputs are sampled every cycle.
module fpga_status_led_ctrl #(
  parameter int NUM_LED   = 4,
  parameter int CNT_WIDTH = 27
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2*NUM_LED-1:0]   mode_i,
  input  logic                   exit_valid_i,
  input  logic [31:0]            exit_value_i,
  input  logic                   clear_i,
  output logic [NUM_LED-1:0]     led_o,
  output logic                   heartbeat_o,
  output logic                   exit_latched_o,
  output logic [31:0]            exit_code_o
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [NUM_LED-1:0]   led_q, led_d;
  logic                 hb_q;
  logic                 latched_q, latched_d;
  logic [31:0]          code_q, code_d;
  logic                 slow, fast;

  assign slow = cnt_q[CNT_WIDTH-1];
  assign fast = cnt_q[CNT_WIDTH-3];

  // clear_i has priority over a same-cycle exit strobe; only RUN accepts a new code.
  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    code_d    = code_q;
    if (clear_i) begin
      state_d   = ST_RUN;
      latched_d = 1'b0;
      code_d    = 32'd0;
    end else if (state_q == ST_RUN && exit_valid_i) begin
      latched_d = 1'b1;
      code_d    = exit_value_i;
      state_d   = (exit_value_i == 32'd0) ? ST_PASS : ST_FAIL;
    end
  end

  // LEDs follow the state being entered so they change on the same edge as the exit latch.
  always_comb begin
    led_d = '0;
    case (state_d)
      ST_PASS: led_d = '1;
      ST_FAIL: led_d = {NUM_LED{fast}};
      default: begin
        for (int k = 0; k < NUM_LED; k++) begin
          case (mode_i[2*k +: 2])
            2'b00:   led_d[k] = 1'b0;
            2'b01:   led_d[k] = 1'b1;
            2'b10:   led_d[k] = slow;
            default: led_d[k] = fast;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      led_q     <= '0;
      hb_q      <= 1'b0;
      latched_q <= 1'b0;
      code_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_q + CNT_WIDTH'(1);
      led_q     <= led_d;
      hb_q      <= slow;
      latched_q <= latched_d;
      code_q    <= code_d;
    end
  end

  assign led_o          = led_q;
  assign heartbeat_o    = hb_q;
  assign exit_latched_o = latched_q;
  assign exit_code_o    = code_q;

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Scoreboard bench for fpga_status_led_ctrl with a cycle-count reference model (CNT_WIDTH=4, NUM_LED=4).
module tb_fpga_status_led_ctrl;
  localparam int W = 4;
  localparam int N = 4;
  localparam int S_RUN = 0, S_PASS = 1, S_FAIL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2*N-1:0] mode = '0;
  logic          ev = 1'b0;
  logic [31:0]   val = '0;
  logic          clr = 1'b0;
  logic [N-1:0]  led;
  logic          hb;
  logic          lat;
  logic [31:0]   code;

  fpga_status_led_ctrl #(.NUM_LED(N), .CNT_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .exit_valid_i(ev),
    .exit_value_i(val), .clear_i(clr), .led_o(led), .heartbeat_o(hb),
    .exit_latched_o(lat), .exit_code_o(code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] led;
    logic         hb;
    logic         lat;
    logic [31:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: cycles elapsed since reset, plus the exit bookkeeping.
  int          m_cnt;
  int          m_state;
  logic        m_lat;
  logic [31:0] m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_state = S_RUN; m_lat = 1'b0; m_code = '0;
  endtask

  // Drive one cycle of inputs at a falling edge, push the expected post-edge outputs, wait a cycle.
  task automatic step(input logic [2*N-1:0] md, input logic e, input logic [31:0] v, input logic c);
    exp_t x;
    int slow, fast;
    mode = md; ev = e; val = v; clr = c;
    slow = (m_cnt / (2 ** (W-1))) % 2;
    fast = (m_cnt / (2 ** (W-3))) % 2;
    if (c) begin
      m_state = S_RUN; m_lat = 1'b0; m_code = '0;
    end else if (m_state == S_RUN && e) begin
      m_lat = 1'b1; m_code = v;
      m_state = (v == 0) ? S_PASS : S_FAIL;
    end
    for (int k = 0; k < N; k++) begin
      if (m_state == S_PASS)      x.led[k] = 1'b1;
      else if (m_state == S_FAIL) x.led[k] = fast[0];
      else begin
        case (int'(md[2*k +: 2]))
          0:       x.led[k] = 1'b0;
          1:       x.led[k] = 1'b1;
          2:       x.led[k] = slow[0];
          default: x.led[k] = fast[0];
        endcase
      end
    end
    x.hb = slow[0]; x.lat = m_lat; x.code = m_code;
    exp_q.push_back(x);
    m_cnt = (m_cnt + 1) % (2 ** W);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [2*N-1:0] md);
    for (int i = 0; i < n; i++) step(md, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_led"}, 32'(led), 32'h0);
    chk({tag, "_hb"},  32'(hb),  32'h0);
    chk({tag, "_lat"}, 32'(lat), 32'h0);
    chk({tag, "_code"}, code,    32'h0);
  endtask

  // Monitor: outputs are compared one time unit after each rising edge.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("led",  32'(led), 32'(x.led));
      chk("hb",   32'(hb),  32'(x.hb));
      chk("lat",  32'(lat), 32'(x.lat));
      chk("code", code,     x.code);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*N-1:0] m4;
    m4 = 8'b11_10_01_00;
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    idle(32, m4);
    step(m4, 1'b1, 32'h0, 1'b0);
    idle(5, m4);
    step(m4, 1'b1, 32'h5, 1'b0);
    idle(5, m4);
    step(m4, 1'b0, 32'h0, 1'b1);
    idle(3, m4);
    step(m4, 1'b1, 32'h7, 1'b1);
    idle(3, m4);
    step(m4, 1'b1, 32'hDEAD_0001, 1'b0);
    idle(10, m4);

    #2 rst = 1'b1;
    #1 chk_zero("rst_midfail");
    @(negedge clk);
    chk_zero("rst_held");
    rst = 1'b0;
    model_reset();
    idle(20, m4);

    for (int i = 0; i < 300; i++) begin
      logic [2*N-1:0] md;
      logic e, c;
      logic [31:0] v;
      md = 8'($urandom_range(0, 255));
      e  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      step(md, e, v, c);
    end

    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
